// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-port operation encodings
// and the address-width derivation used by the top-level port list.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } wr_op_e;

  // Address width for a bank of 'depth' entries; at least one bit even for
  // tiny banks so the address ports never collapse to zero width.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_alu_op.sv
// Combinational next-value / wrap computation for one register entry.
// Shared by the write path and the read-bypass path so both agree.
// Ports:
//   cur      current entry value
//   op       operation (LOAD/INC/DEC/CLR)
//   data     load data (ignored for other ops)
//   next_val value the entry takes after the operation
//   wrap     1 when INC of all-ones or DEC of zero
module reg_alu_op
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  wr_op_e           op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next_val,
  output logic             wrap
);

  always_comb begin
    next_val = cur;
    wrap     = 1'b0;
    unique case (op)
      OP_LOAD: next_val = data;
      OP_INC: begin
        next_val = cur + WIDTH'(1);
        wrap     = &cur;
      end
      OP_DEC: begin
        next_val = cur - WIDTH'(1);
        wrap     = ~|cur;
      end
      OP_CLR:  next_val = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: DEPTH entries of WIDTH bits, one
// write/modify port (LOAD/INC/DEC/CLR) and two registered read ports.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_enable/op/addr/data write-port request
//   rd_enable             update both read outputs this cycle
//   rd_addr_a/b           read addresses
//   rd_data_a/b           registered read data (1-cycle latency)
//   wrap                  registered pulse after an INC/DEC wrap-around
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_enable,
  input  logic [1:0]        wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              wrap
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] wr_cur;
  logic             wr_ok;
  logic             wr_go;
  logic [WIDTH-1:0] alu_next;
  logic             alu_wrap;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;

  // Address decode by comparison against each entry index keeps
  // non-power-of-two depths free of out-of-range array selects.
  always_comb begin
    wr_cur = '0;
    wr_ok  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        wr_cur = mem[i];
        wr_ok  = !(ZERO_REG && (i == 0));
      end
    end
  end

  assign wr_go = wr_enable && wr_ok;

  reg_alu_op #(
    .WIDTH(WIDTH)
  ) u_alu (
    .cur      (wr_cur),
    .op       (wr_op_e'(wr_op)),
    .data     (wr_data),
    .next_val (alu_next),
    .wrap     (alu_wrap)
  );

  // Invalid addresses and the hardwired zero entry fall through to '0.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG && (i == 0))) begin
        if (rd_addr_a == ADDR_W'(i)) begin
          rd_next_a = (BYPASS && wr_go && (wr_addr == rd_addr_a)) ? alu_next : mem[i];
        end
        if (rd_addr_b == ADDR_W'(i)) begin
          rd_next_b = (BYPASS && wr_go && (wr_addr == rd_addr_b)) ? alu_next : mem[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= wr_go && alu_wrap;
      if (rd_enable) begin
        rd_data_a <= rd_next_a;
        rd_data_b <= rd_next_b;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_go && (wr_addr == ADDR_W'(i))) begin
          mem[i] <= alu_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: two instances share one stimulus stream.
//   u0: DEPTH=4, ZERO_REG=0, BYPASS=1 (defaults)
//   u1: DEPTH=3, ZERO_REG=1, BYPASS=0
// Both are compared every cycle against an array-based reference model;
// directed vectors and sequences add hand-derived expectations.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_enable = 1'b0;
  logic [1:0] wr_op = 2'b00;
  logic [1:0] wr_addr = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       rd_enable = 1'b0;
  logic [1:0] rd_addr_a = 2'b00;
  logic [1:0] rd_addr_b = 2'b00;
  logic [7:0] a0, b0, a1, b1;
  logic       w0, w1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_bank u0 (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_op(wr_op),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_enable(rd_enable),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a0), .rd_data_b(b0), .wrap(w0)
  );

  reg_bank #(
    .WIDTH(8), .DEPTH(3), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_op(wr_op),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_enable(rd_enable),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a1), .rd_data_b(b1), .wrap(w1)
  );

  // ---------------- reference model ----------------
  int unsigned m [2][4];
  int unsigned ea [2];
  int unsigned eb [2];
  int unsigned ew [2];

  function automatic int unsigned dep(input int d);
    return (d == 0) ? 4 : 3;
  endfunction
  function automatic bit zr(input int d);
    return d != 0;
  endfunction
  function automatic bit byp(input int d);
    return d == 0;
  endfunction

  function automatic int unsigned model_read(input int d, input int unsigned a,
                                             input bit wv, input int unsigned nv);
    if (a >= dep(d) || (zr(d) && a == 0)) return 0;
    if (byp(d) && wv && int'(wr_addr) == int'(a)) return nv;
    return m[d][a];
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int unsigned wa, old, nv;
      bit wv, wrp;
      wa  = wr_addr;
      wv  = wr_enable && (wa < dep(d)) && !(zr(d) && wa == 0);
      old = (wa < dep(d)) ? m[d][wa] : 0;
      case (wr_op)
        2'd0:    nv = wr_data;
        2'd1:    nv = (old + 1) % 256;
        2'd2:    nv = (old + 255) % 256;
        default: nv = 0;
      endcase
      wrp = wv && ((wr_op == 2'd1 && old == 255) || (wr_op == 2'd2 && old == 0));
      if (reset) begin
        for (int k = 0; k < 4; k++) m[d][k] = 0;
        ea[d] = 0; eb[d] = 0; ew[d] = 0;
      end else begin
        if (rd_enable) begin
          ea[d] = model_read(d, rd_addr_a, wv, nv);
          eb[d] = model_read(d, rd_addr_b, wv, nv);
        end
        ew[d] = wrp ? 1 : 0;
        if (wv) m[d][wa] = nv;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit we, input bit [1:0] op, input bit [1:0] wa,
                       input bit [7:0] wd, input bit re, input bit [1:0] ra, input bit [1:0] rb);
    reset = rst; wr_enable = we; wr_op = op; wr_addr = wa; wr_data = wd;
    rd_enable = re; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  // One clock edge: advance the model, then compare both DUTs to it.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " u0.a"}, a0, ea[0]);
    check({tag, " u0.b"}, b0, eb[0]);
    check({tag, " u0.wrap"}, w0, ew[0]);
    check({tag, " u1.a"}, a1, ea[1]);
    check({tag, " u1.b"}, b1, eb[1]);
    check({tag, " u1.wrap"}, w1, ew[1]);
  endtask

  // ---------------- directed vectors (u0 expectations) ----------------
  typedef struct {
    bit rst; bit we; bit [1:0] op; bit [1:0] wa; bit [7:0] wd;
    bit re; bit [1:0] ra; bit [1:0] rb;
    bit [7:0] xa; bit [7:0] xb; bit xw;
  } vec_t;

  vec_t tbl [18];

  initial begin
    //            rst we op wa wd     re ra rb  xa     xb     xw
    tbl[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0};
    tbl[1]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 8'h00, 0};
    tbl[2]  = '{0, 0, 0, 0, 8'h00, 1, 2, 3, 8'h00, 8'h00, 0};
    tbl[3]  = '{0, 1, 0, 2, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 0};
    tbl[4]  = '{0, 0, 0, 0, 8'h00, 1, 2, 2, 8'hA5, 8'hA5, 0};
    tbl[5]  = '{0, 1, 0, 1, 8'hFF, 1, 1, 2, 8'hFF, 8'hA5, 0};
    tbl[6]  = '{0, 1, 1, 1, 8'h00, 0, 0, 0, 8'hFF, 8'hA5, 1};
    tbl[7]  = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 0};
    tbl[8]  = '{0, 1, 2, 1, 8'h00, 1, 1, 1, 8'hFF, 8'hFF, 1};
    tbl[9]  = '{0, 1, 0, 1, 8'h12, 0, 0, 0, 8'hFF, 8'hFF, 0};
    tbl[10] = '{0, 1, 0, 3, 8'h05, 1, 3, 1, 8'h05, 8'h12, 0};
    tbl[11] = '{0, 1, 1, 3, 8'h00, 1, 3, 3, 8'h06, 8'h06, 0};
    tbl[12] = '{0, 1, 3, 3, 8'h00, 1, 3, 2, 8'h00, 8'hA5, 0};
    tbl[13] = '{0, 1, 2, 3, 8'h00, 0, 0, 0, 8'h00, 8'hA5, 1};
    tbl[14] = '{1, 1, 0, 2, 8'h3C, 1, 2, 2, 8'h00, 8'h00, 0};
    tbl[15] = '{0, 0, 0, 0, 8'h00, 1, 2, 3, 8'h00, 8'h00, 0};
    tbl[16] = '{0, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0};
    tbl[17] = '{0, 0, 1, 0, 8'h00, 1, 0, 0, 8'h01, 8'h01, 0};

    for (int k = 0; k < 4; k++) begin
      m[0][k] = 0; m[1][k] = 0;
    end
    ea = '{0, 0}; eb = '{0, 0}; ew = '{0, 0};

    // Unknown pre-reset outputs must not be compared: reset first, untimed.
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    model_step();
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].we, tbl[i].op, tbl[i].wa, tbl[i].wd,
            tbl[i].re, tbl[i].ra, tbl[i].rb);
      tick(tag);
      check({tag, " const.a"}, a0, tbl[i].xa);
      check({tag, " const.b"}, b0, tbl[i].xb);
      check({tag, " const.wrap"}, w0, tbl[i].xw);
    end

    // Zero register: u1 ignores writes to entry 0, u0 stores them.
    drive(0, 1, 0, 0, 8'h77, 0, 0, 0);
    tick("zr_load");
    drive(0, 0, 0, 0, 8'h00, 1, 0, 0);
    tick("zr_read");
    check("zr u0.a", a0, 8'h77);
    check("zr u1.a", a1, 8'h00);
    check("zr u1.b", b1, 8'h00);

    // Bypass vs no-bypass on INC of 5 with same-cycle read.
    drive(0, 1, 0, 2, 8'h05, 0, 0, 0);
    tick("byp_load");
    drive(0, 1, 1, 2, 8'h00, 1, 2, 2);
    tick("byp_inc");
    check("byp u0.a", a0, 8'h06);
    check("byp u1.a", a1, 8'h05);
    check("byp u1.b", b1, 8'h05);
    drive(0, 0, 0, 0, 8'h00, 1, 2, 2);
    tick("byp_after");
    check("byp after u1.a", a1, 8'h06);

    // Address 3 is invalid for the 3-entry bank: no write, no wrap, reads 0.
    drive(0, 1, 0, 3, 8'hFF, 0, 0, 0);
    tick("inv_load");
    drive(0, 1, 1, 3, 8'h00, 1, 3, 2);
    tick("inv_inc");
    check("inv u0.wrap", w0, 1);
    check("inv u1.wrap", w1, 0);
    check("inv u0.a", a0, 8'h00);
    check("inv u1.a", a1, 8'h00);
    check("inv u1.b", b1, 8'h06);

    // Randomised phase, biased toward wrap boundaries and address collisions.
    for (int i = 0; i < 600; i++) begin
      bit [7:0] wd;
      case ($urandom_range(0, 3))
        0:       wd = 8'hFF;
        1:       wd = 8'h00;
        default: wd = 8'($urandom);
      endcase
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 2'($urandom), wd,
            1'($urandom), 2'($urandom), 2'($urandom));
      tick($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
